// File: rtl/bepu_input_reader_if.sv
// Read bus between the CPU front end and the board input reader.
// BEPU_INPUT_IRQ_EN adds the mask write path (FEPU_BEPU_w, FEPU_BEPU_data).
interface bepu_input_reader_if;
   logic        sel;
   logic        FEPU_BEPU_r;
   logic [31:0] FEPU_BEPU_addr;
   logic [31:0] BEPU_FEPU_data;
   logic        BEPU_FEPU_valid;
`ifdef BEPU_INPUT_IRQ_EN
   logic        FEPU_BEPU_w;
   logic [31:0] FEPU_BEPU_data;

   modport master (
      output sel, FEPU_BEPU_r, FEPU_BEPU_addr,
      output FEPU_BEPU_w, FEPU_BEPU_data,
      input  BEPU_FEPU_data, BEPU_FEPU_valid
   );
   modport slave (
      input  sel, FEPU_BEPU_r, FEPU_BEPU_addr,
      input  FEPU_BEPU_w, FEPU_BEPU_data,
      output BEPU_FEPU_data, BEPU_FEPU_valid
   );
`else
   modport master (
      output sel, FEPU_BEPU_r, FEPU_BEPU_addr,
      input  BEPU_FEPU_data, BEPU_FEPU_valid
   );
   modport slave (
      input  sel, FEPU_BEPU_r, FEPU_BEPU_addr,
      output BEPU_FEPU_data, BEPU_FEPU_valid
   );
`endif
endinterface

// File: rtl/bepu_input_reader.sv
// Board input reader: sync + debounce of 8 switches / 4 buttons, edge and press counting.
// Optional BEPU_INPUT_IRQ_EN adds a masked edge interrupt and a mask write port.
module bepu_input_reader #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CNT_W           = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   bepu_input_reader_if.slave     bus,
   input  logic [7:0]             SW_raw,
   input  logic [3:0]             BTN_raw
`ifdef BEPU_INPUT_IRQ_EN
   ,
   output logic                   irq
`endif
);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [11:0]      w_raw;
   logic [11:0]      r_sync1;
   logic [11:0]      r_sync2;
   logic [11:0]      r_db;
   logic [CNT_W-1:0] r_cnt [12];
   logic [11:0]      w_flip;
   logic [3:0]       w_rise;
   logic [3:0]       r_edge;
   logic [3:0]       w_edge_nxt;
   logic [15:0]      r_press_cnt;
   logic [15:0]      w_inc;
   logic [15:0]      w_cnt_nxt;
   logic [31:0]      r_data;
   logic             r_valid;
   logic [31:0]      w_word;
   logic             w_rd;
   logic             w_clr_edge;
   logic             w_clr_cnt;
   logic [1:0]       w_reg;
   logic             w_unused_addr;

   assign w_raw = {BTN_raw, SW_raw};
   assign w_reg = bus.FEPU_BEPU_addr[3:2];
   assign w_unused_addr = ^{bus.FEPU_BEPU_addr[31:4], bus.FEPU_BEPU_addr[1:0]};

   // A bit flips when it has disagreed with the debounced value long enough
   always_comb begin
      w_flip = '0;
      for (int i = 0; i < 12; i++)
         w_flip[i] = (r_sync2[i] != r_db[i]) && (r_cnt[i] == LP_LAST);
   end

   assign w_rise = w_flip[11:8] & r_sync2[11:8];
   assign w_inc  = 16'(w_rise[0]) + 16'(w_rise[1])
                 + 16'(w_rise[2]) + 16'(w_rise[3]);

   assign w_rd       = bus.sel & bus.FEPU_BEPU_r;
   assign w_clr_edge = w_rd && (w_reg == 2'b10);
   assign w_clr_cnt  = w_rd && (w_reg == 2'b11);

   // New events are OR-ed/added after the clear so they survive a same-cycle read
   assign w_edge_nxt = (w_clr_edge ? 4'b0 : r_edge) | w_rise;
   assign w_cnt_nxt  = (w_clr_cnt ? 16'h0 : r_press_cnt) + w_inc;

   always_comb begin
      w_word = 32'h0;
      case (w_reg)
         2'b00: w_word = {24'b0, r_db[7:0]};
         2'b01: w_word = {28'b0, r_db[11:8]};
         2'b10: w_word = {28'b0, r_edge};
         2'b11: w_word = {16'b0, r_press_cnt};
         default: w_word = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_db        <= '0;
         for (int i = 0; i < 12; i++)
            r_cnt[i] <= '0;
         r_edge      <= '0;
         r_press_cnt <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 12; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_cnt[i] <= '0;
            end else if (w_flip[i]) begin
               r_db[i]  <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
         r_edge      <= w_edge_nxt;
         r_press_cnt <= w_cnt_nxt;
         r_data      <= w_rd ? w_word : 32'h0;
         r_valid     <= w_rd;
      end
   end

   assign bus.BEPU_FEPU_data  = r_data;
   assign bus.BEPU_FEPU_valid = r_valid;

`ifdef BEPU_INPUT_IRQ_EN
   logic [3:0] r_mask;
   logic       r_irq;
   logic       w_unused_wdata;

   assign w_unused_wdata = ^bus.FEPU_BEPU_data[31:4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mask <= 4'b1111;
         r_irq  <= 1'b0;
      end else begin
         if (bus.sel && bus.FEPU_BEPU_w && (w_reg == 2'b10))
            r_mask <= bus.FEPU_BEPU_data[3:0];
         r_irq <= |(r_edge & r_mask);
      end
   end

   assign irq = r_irq;
`endif

endmodule

// File: tb/tb_bepu_input_reader.sv
// Directed bench for bepu_input_reader with DEBOUNCE_CYCLES=4.
// Build with BEPU_INPUT_IRQ_EN to also exercise the interrupt mask path.
module tb_bepu_input_reader;
   logic       clk;
   logic       rst;
   logic [7:0] SW_raw;
   logic [3:0] BTN_raw;
`ifdef BEPU_INPUT_IRQ_EN
   logic       irq;
`endif

   int tests;
   int fails;

   bepu_input_reader_if bus ();

   bepu_input_reader #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .SW_raw(SW_raw),
      .BTN_raw(BTN_raw)
`ifdef BEPU_INPUT_IRQ_EN
      ,
      .irq(irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++)
         tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                          output logic v);
      bus.sel            = 1'b1;
      bus.FEPU_BEPU_r    = 1'b1;
      bus.FEPU_BEPU_addr = a;
      tick();
      d = bus.BEPU_FEPU_data;
      v = bus.BEPU_FEPU_valid;
      bus.sel         = 1'b0;
      bus.FEPU_BEPU_r = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a,
                         input logic [31:0] exp);
      logic [31:0] d;
      logic        v;
      do_read(a, d, v);
      check({tag, "_valid"}, {31'b0, v}, 32'd1);
      check(tag, d, exp);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst                = 1'b1;
      SW_raw             = 8'hA5;
      BTN_raw            = 4'h0;
      bus.sel            = 1'b0;
      bus.FEPU_BEPU_r    = 1'b0;
      bus.FEPU_BEPU_addr = 32'h0;
`ifdef BEPU_INPUT_IRQ_EN
      bus.FEPU_BEPU_w    = 1'b0;
      bus.FEPU_BEPU_data = 32'h0;
`endif
      wait_n(3);
      check("rst_valid", {31'b0, bus.BEPU_FEPU_valid}, 32'd0);
      check("rst_data", bus.BEPU_FEPU_data, 32'h0);
      rst = 1'b0;
      wait_n(8);
      rd_chk("sw_pre", 32'h0, 32'h0000_00A5);

      // reset lands while a read response is on the bus
      bus.sel            = 1'b1;
      bus.FEPU_BEPU_r    = 1'b1;
      bus.FEPU_BEPU_addr = 32'h0;
      tick();
      bus.sel         = 1'b0;
      bus.FEPU_BEPU_r = 1'b0;
      rst = 1'b1;
      #1;
      check("midrd_valid", {31'b0, bus.BEPU_FEPU_valid}, 32'd0);
      check("midrd_data", bus.BEPU_FEPU_data, 32'h0);
      wait_n(2);
      rst = 1'b0;
      wait_n(5);
      rd_chk("sw_early", 32'h0, 32'h0);
      rd_chk("sw_ready", 32'h0, 32'h0000_00A5);
      tick();
      check("idle_valid", {31'b0, bus.BEPU_FEPU_valid}, 32'd0);
      check("idle_data", bus.BEPU_FEPU_data, 32'h0);

      // 3-cycle glitch on BTN[1] must be rejected
      BTN_raw = 4'b0010;
      wait_n(3);
      BTN_raw = 4'b0000;
      wait_n(8);
      rd_chk("glitch_btn", 32'h4, 32'h0);
      rd_chk("glitch_edge", 32'h8, 32'h0);
      rd_chk("glitch_cnt", 32'hC, 32'h0);
      BTN_raw = 4'b0010;
      wait_n(8);
      rd_chk("hold_btn", 32'h4, 32'h2);
      rd_chk("hold_edge", 32'h8, 32'h2);
      rd_chk("hold_cnt", 32'hC, 32'h1);

      // two more buttons: edge 0101, clear-on-read
      BTN_raw = 4'b0111;
      wait_n(8);
      rd_chk("edge5", 32'h8, 32'h5);
      rd_chk("edge_clr", 32'h8, 32'h0);
      rd_chk("cnt2", 32'hC, 32'h2);
      rd_chk("cnt_clr", 32'hC, 32'h0);

      // clear of edge in the same cycle as BTN[3] rising
      BTN_raw = 4'b0000;
      wait_n(8);
      BTN_raw = 4'b0010;
      wait_n(8);
      BTN_raw = 4'b1010;
      wait_n(5);
      rd_chk("same_old", 32'h8, 32'h2);
      rd_chk("same_new", 32'h8, 32'h8);
      rd_chk("same_cnt", 32'hC, 32'h2);

      // wrap from 0xFFFF with two simultaneous presses
      BTN_raw = 4'b0000;
      wait_n(8);
      BTN_raw = 4'b0101;
      wait_n(5);
      force dut.r_press_cnt = 16'hFFFF;
      #1;
      release dut.r_press_cnt;
      tick();
      rd_chk("wrap_cnt", 32'hC, 32'h1);

      // unselected reads leave edge and press_cnt alone
      BTN_raw = 4'b0111;
      wait_n(8);
      bus.sel            = 1'b0;
      bus.FEPU_BEPU_r    = 1'b1;
      bus.FEPU_BEPU_addr = 32'h8;
      tick();
      check("unsel8_valid", {31'b0, bus.BEPU_FEPU_valid}, 32'd0);
      check("unsel8_data", bus.BEPU_FEPU_data, 32'h0);
      bus.FEPU_BEPU_addr = 32'hC;
      tick();
      check("unselC_valid", {31'b0, bus.BEPU_FEPU_valid}, 32'd0);
      bus.FEPU_BEPU_r = 1'b0;
      tick();
      rd_chk("unsel_edge", 32'h8, 32'h7);
      rd_chk("unsel_cnt", 32'hC, 32'h1);
      rd_chk("btn_all", 32'h4, 32'h7);

`ifdef BEPU_INPUT_IRQ_EN
      BTN_raw = 4'b0000;
      wait_n(8);
      bus.sel            = 1'b1;
      bus.FEPU_BEPU_w    = 1'b1;
      bus.FEPU_BEPU_addr = 32'h8;
      bus.FEPU_BEPU_data = 32'h1;
      tick();
      bus.sel         = 1'b0;
      bus.FEPU_BEPU_w = 1'b0;
      BTN_raw = 4'b0010;
      wait_n(8);
      check("irq_masked", {31'b0, irq}, 32'd0);
      BTN_raw = 4'b0011;
      wait_n(8);
      check("irq_set", {31'b0, irq}, 32'd1);
      rd_chk("irq_edge", 32'h8, 32'h3);
      tick();
      check("irq_drop", {31'b0, irq}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
